// File: rtl/foc_pkg.sv
// foc_pkg: shared PI controller FSM state, default widths and the clamp helper.
package foc_pkg;
  localparam int PI_N = 10;
  localparam int PI_F = 9;
  localparam int PI_GF = 8;
  localparam int PI_SW = 2 * PI_N + 2;
  typedef enum logic [1:0] {IDLE, ERR, MUL, SUM} pi_state_t;
  // Crossed bounds (lo > hi) resolve to hi.
  function automatic logic signed [PI_SW-1:0] clamp(
    input logic signed [PI_SW-1:0] v,
    input logic signed [PI_SW-1:0] lo,
    input logic signed [PI_SW-1:0] hi
  );
    return (v > hi || lo > hi) ? hi : (v < lo) ? lo : v;
  endfunction
endpackage

// File: rtl/saturation.sv
// saturation: clamps a signed Q(N-F-1).F value to [i_min, i_max]; i_max wins when the bounds cross.
module saturation #(
  parameter int N = 10,
  parameter int F = 9,
  localparam int I = N - F - 1
) (
  input  logic signed [I+F:0] i_x,
  input  logic signed [I+F:0] i_min,
  input  logic signed [I+F:0] i_max,
  output logic signed [I+F:0] o_y
);
  always_comb o_y = (i_x > i_max || i_min > i_max) ? i_max : (i_x < i_min) ? i_min : i_x;
endmodule

// File: rtl/pi_controller.sv
// pi_controller: 4-cycle discrete PI regulator with clamping anti-windup.
// Defining PI_INTEG_FREEZE_EN adds i_freeze, which holds the integrator for that sample.
module pi_controller
  import foc_pkg::*;
#(
  parameter int N = PI_N,
  parameter int F = PI_F,
  parameter int GF = PI_GF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic signed [N-1:0] i_ref,
  input  logic signed [N-1:0] i_meas,
  input  logic signed [N-1:0] i_kp,
  input  logic signed [N-1:0] i_ki,
  input  logic signed [N-1:0] i_max,
  input  logic signed [N-1:0] i_min,
  input  logic                i_clear,
`ifdef PI_INTEG_FREEZE_EN
  input  logic                i_freeze,
`endif
  output logic                o_out_valid,
  output logic signed [N-1:0] o_y
);
  localparam int EW = N + 1;
  localparam int PW = 2 * N + 1;
  localparam int IW = N + 2;
  localparam int SW = 2 * N + 2;
  pi_state_t r_state, w_next;
  logic signed [N-1:0] r_ref, r_meas, r_kp, r_ki, r_min, r_max, r_y, w_y;
  logic signed [EW-1:0] r_e;
  logic signed [PW-1:0] r_p, r_di, w_kp_e, w_ki_e;
  logic signed [IW-1:0] r_integ;
  logic signed [SW-1:0] w_min, w_max, w_integ, w_integ_n, w_s, w_s_c;
  logic w_take, w_freeze;
  assign w_take = i_in_valid && o_in_ready;
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_comb
    w_next = (r_state == IDLE) ? (w_take ? ERR : IDLE) :
             (r_state == ERR)  ? MUL :
             (r_state == MUL)  ? SUM : IDLE;
  always_comb begin
    o_in_ready  = !rst && r_state == IDLE;
    o_out_valid = !rst && r_state == SUM;
    o_y         = o_out_valid ? w_y : r_y;
  end
`ifdef PI_INTEG_FREEZE_EN
  logic r_freeze;
  always_ff @(posedge clk) if (w_take) r_freeze <= i_freeze;
  assign w_freeze = r_freeze;
`else
  assign w_freeze = 1'b0;
`endif
  assign w_kp_e    = PW'(r_kp) * PW'(r_e);
  assign w_ki_e    = PW'(r_ki) * PW'(r_e);
  assign w_min     = SW'(r_min);
  assign w_max     = SW'(r_max);
  assign w_integ   = SW'(r_integ);
  assign w_integ_n = w_freeze ? w_integ : clamp(w_integ + SW'(r_di), w_min, w_max);
  assign w_s       = SW'(r_p) + w_integ_n;
  // Wide pre-clamp keeps the N-bit truncation lossless before the saturation stage.
  assign w_s_c     = clamp(w_s, w_min, w_max);
  saturation #(.N(N), .F(F)) u_sat (
    .i_x  (N'(w_s_c)),
    .i_min(r_min),
    .i_max(r_max),
    .o_y  (w_y)
  );
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_ref  <= i_ref;
      r_meas <= i_meas;
      r_kp   <= i_kp;
      r_ki   <= i_ki;
      r_min  <= i_min;
      r_max  <= i_max;
    end
    if (r_state == ERR) r_e <= EW'(r_ref) - EW'(r_meas);
    if (r_state == MUL) begin
      r_p  <= w_kp_e >>> GF;
      r_di <= w_ki_e >>> GF;
    end
    if (rst) begin
      r_integ <= '0;
      r_y     <= '0;
    end else begin
      if (i_clear) r_integ <= '0;
      else if (r_state == SUM) r_integ <= IW'(w_integ_n);
      if (r_state == SUM) r_y <= w_y;
    end
  end
endmodule

// File: tb/tb_pi_controller.sv
// tb_pi_controller: directed vectors with hand-computed outputs for pi_controller.
module tb_pi_controller;
  logic clk = 1'b0, rst = 1'b1, i_in_valid = 1'b0, i_clear = 1'b0, i_freeze = 1'b0;
  logic o_in_ready, o_out_valid;
  logic signed [9:0] i_ref = '0, i_meas = '0, i_kp = '0, i_ki = '0, i_max = '0, i_min = '0, o_y;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  pi_controller dut (
    .clk(clk), .rst(rst), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_ref(i_ref), .i_meas(i_meas), .i_kp(i_kp), .i_ki(i_ki), .i_max(i_max), .i_min(i_min),
    .i_clear(i_clear),
`ifdef PI_INTEG_FREEZE_EN
    .i_freeze(i_freeze),
`endif
    .o_out_valid(o_out_valid), .o_y(o_y)
  );
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic clr_integ();
    @(negedge clk);
    i_clear = 1'b1;
    @(posedge clk);
    #1 i_clear = 1'b0;
  endtask
  // One sample: checks ready, busy during ERR, latency 3 and y; clr selects the cycle clear is held.
  task automatic run(input string tag, input int r, m, p, i, lo, hi, clr, exp_y);
    int y, lat;
    @(negedge clk);
    i_ref = 10'(r); i_meas = 10'(m); i_kp = 10'(p); i_ki = 10'(i); i_min = 10'(lo); i_max = 10'(hi);
    i_in_valid = 1'b1;
    chk({tag, ".rdy"}, int'(o_in_ready), 1);
    @(posedge clk);
    #1 i_in_valid = 1'b0;
    lat = 0;
    y = 9999;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      i_clear = (k == clr);
      if (k == 1) begin
        chk({tag, ".busy"}, int'(o_in_ready), 0);
        i_in_valid = 1'b1;
        i_ref = -10'sd7; i_meas = 10'sd33; i_kp = 10'sd5; i_ki = 10'sd9; i_min = -10'sd1; i_max = 10'sd1;
      end else i_in_valid = 1'b0;
      if (o_out_valid) begin
        lat = k;
        y = int'(o_y);
      end
    end
    @(posedge clk);
    #1 begin
      i_clear = 1'b0;
      i_in_valid = 1'b0;
    end
    chk({tag, ".lat"}, lat, 3);
    chk({tag, ".y"}, y, exp_y);
  endtask
  initial begin
    int n_ov;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.ready", int'(o_in_ready), 0);
    chk("rst.ov", int'(o_out_valid), 0);
    chk("rst.y", int'(o_y), 0);
    rst = 1'b0;
    #1 chk("rst.release", int'(o_in_ready), 1);
    run("p_only", 200, 0, 128, 0, -512, 511, 0, 100);
    run("p_trunc", -3, 0, 128, 0, -512, 511, 0, -2);
    run("p_min", -300, 0, 256, 0, -200, 511, 0, -200);
    clr_integ();
    run("i1", 200, 0, 0, 64, -512, 511, 0, 50);
    run("i2", 200, 0, 0, 64, -512, 511, 0, 100);
    run("i3", 200, 0, 0, 64, -512, 511, 0, 150);
    run("i4", 200, 0, 0, 64, -512, 511, 0, 200);
    clr_integ();
    run("aw1", 200, 0, 0, 64, -512, 120, 0, 50);
    run("aw2", 200, 0, 0, 64, -512, 120, 0, 100);
    run("aw3", 200, 0, 0, 64, -512, 120, 0, 120);
    run("aw4", 200, 0, 0, 64, -512, 120, 0, 120);
    run("aw_rev", 0, 200, 0, 64, -512, 120, 0, 70);
    clr_integ();
    run("sat_hi", 511, -512, 256, 0, -512, 511, 0, 511);
    run("sat_lo", -512, 511, 256, 0, -512, 511, 0, -512);
    run("crossed", 200, 0, 128, 0, 100, -100, 0, -100);
    clr_integ();
    run("pre_rst", 200, 0, 0, 64, -512, 511, 0, 50);
    @(negedge clk);
    i_ref = 10'sd200; i_meas = '0; i_kp = 10'sd128; i_ki = 10'sd64; i_min = -10'sd512; i_max = 10'sd511;
    i_in_valid = 1'b1;
    @(posedge clk);
    #1 i_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 begin
      chk("rst_mul.ready", int'(o_in_ready), 0);
      chk("rst_mul.ov", int'(o_out_valid), 0);
    end
    @(negedge clk);
    chk("rst_mul.y", int'(o_y), 0);
    rst = 1'b0;
    #1 chk("rst_mul.release", int'(o_in_ready), 1);
    n_ov = 0;
    repeat (4) begin
      @(negedge clk);
      n_ov += int'(o_out_valid);
    end
    chk("rst_mul.no_ov", n_ov, 0);
    run("rst_integ0", 200, 0, 0, 64, -512, 511, 0, 50);
    run("clr_sum", 200, 0, 0, 64, -512, 511, 3, 100);
    run("clr_after", 200, 0, 0, 64, -512, 511, 0, 50);
    run("clr_err", 200, 0, 0, 64, -512, 511, 1, 50);
`ifdef PI_INTEG_FREEZE_EN
    clr_integ();
    run("fz_i1", 200, 0, 0, 64, -512, 511, 0, 50);
    run("fz_i2", 200, 0, 0, 64, -512, 511, 0, 100);
    i_freeze = 1'b1;
    run("fz_hold1", 200, 0, 0, 64, -512, 511, 0, 100);
    run("fz_hold2", 200, 0, 0, 64, -512, 511, 0, 100);
    i_freeze = 1'b0;
    run("fz_release", 200, 0, 0, 64, -512, 511, 0, 150);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
